mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Round-robin arbiter and sequencer that shares a single shift-add multiplier (St/Done handshake, WIDTH×WIDTH → 2·WIDTH product) among NREQ requesters. It latches the winning requester's operands, pulses the multiplier start, waits for its done indication, and returns the product to the winner with a one-cycle acknowledge. It sits between the multiplier datapath/controller pair and the units (e.g. execute-stage M-extension paths) that need multiplication.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width in bits
- TIMEOUT, 64, max WAIT cycles before abort (used only with the configuration macro)

- Clk  in  1  single clock, all state on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Req  in  NREQ  per-requester request level
- OpA  in  NREQ·WIDTH  multiplicand, requester i at bits [i·WIDTH +: WIDTH]
- OpB  in  NREQ·WIDTH  multiplier, same packing
- Ack  out  NREQ  one-hot, one-cycle completion pulse
- Result  out  2·WIDTH  product, valid only while Ack ≠ 0
- Err  out  1  timeout flag, valid only while Ack ≠ 0
- Busy  out  1  high in every state except IDLE
- MulSt  out  1  start pulse to multiplier
- MulA  out  WIDTH  registered operand A to multiplier
- MulB  out  WIDTH  registered operand B to multiplier
- MulDone  in  1  multiplier done indication
- MulP  in  2·WIDTH  multiplier product, sampled when MulDone is high in WAIT

## Operation
- States: IDLE, START, WAIT, RESP; encoding 2 bits, reset to IDLE.
- IDLE: if Req ≠ 0, pick winner g = first set bit scanning upward (wrapping) from last+1; latch g, OpA[g], OpB[g] into MulA/MulB; go START. Else stay.
- START: MulSt = 1 for exactly this cycle; go WAIT.
- WAIT: if MulDone, latch MulP into Result register, go RESP; else stay. MulDone ignored in all other states.
- RESP: Ack[g] = 1, Result and Err driven; last ← g; go IDLE.
- Pointer last resets to NREQ−1, so requester 0 has priority after reset.
- Requester must hold Req and operands until its Ack. Req deasserted before grant: not served. Req deasserted after grant: operation completes, Ack still pulses.
- A requester still requesting after its Ack competes normally; with others pending it gets lowest priority.
- MulA/MulB hold stable from START through RESP.
- Rst_n low at any time (including mid-WAIT): all registers cleared immediately; in-flight operation discarded, no Ack.

## Timing
- Reset values: Ack = 0, Result = 0, Err = 0, Busy = 0, MulSt = 0, MulA = 0, MulB = 0, last = NREQ−1.
- All outputs registered or decoded from state only; no combinational path from Req/MulDone to any output.
- Req seen at edge t → START at t+1 (MulSt high cycle t+1..t+2) → WAIT.
- MulDone sampled at edge u → Ack high for cycle u..u+1.
- Minimum request-to-Ack latency: 3 cycles + multiplier latency; minimum spacing between successive Acks: 4 cycles.
- Busy rises one cycle after grant edge, falls in IDLE.

## Configuration
- MUL_ARB_TIMEOUT_EN defined: WAIT counts cycles from 0; on reaching TIMEOUT without MulDone, go RESP with Err = 1, Result = 0; counter cleared on leaving WAIT. MulDone in same cycle as the terminal count wins (Err = 0).
- Not defined: no counter, WAIT exits only on MulDone, Err tied 0.

## Test plan
- Reset: Rst_n low mid-cycle → all outputs 0 asynchronously, state IDLE; release → Busy 0.
- Single request: Req = 0001, OpA[0] = 13, OpB[0] = 11, model multiplier done after 10 cycles → MulSt one pulse, MulA = 13, MulB = 11, Ack = 0001 with Result = 143, Err = 0.
- Round-robin: Req = 1111 held, distinct operands → Ack order 0,1,2,3,0; each Result matches its operands (e.g. 255×255 = 65025 for requester 3).
- Skip/wrap: last = 2, Req = 0011 → requester 0 first, then 1; Req dropped for 1 before grant → not served.
- Reset mid-WAIT: assert Rst_n low while WAIT → no Ack, next request served normally with correct product.
- Timeout (MUL_ARB_TIMEOUT_EN, TIMEOUT = 64): MulDone never asserted → Ack after 64 WAIT cycles with Err = 1, Result = 0; MulDone exactly on cycle 64 → Err = 0, Result = MulP.

Source files
------------

// File: rtl/mul_arbiter_if.sv
// Requester-side and multiplier-side signals of the shared-multiplier arbiter.
// master = arbiter view, slave = environment (requesters plus multiplier) view.
interface mul_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ-1:0]       ack;
  logic [2*WIDTH-1:0]    result;
  logic                  err;
  logic                  busy;
  logic                  mul_st;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    mul_p;

  modport master (
    input  req, op_a, op_b, mul_done, mul_p,
    output ack, result, err, busy, mul_st, mul_a, mul_b
  );

  modport slave (
    output req, op_a, op_b, mul_done, mul_p,
    input  ack, result, err, busy, mul_st, mul_a, mul_b
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one St/Done multiplier among NREQ requesters; grant->MulSt next cycle, Ack one cycle after MulDone.
// Requesters hold Req until Ack; MUL_ARB_TIMEOUT_EN adds a WAIT watchdog that aborts with Err after TIMEOUT cycles.
module mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst_n,
  mul_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t             state, state_nx;
  logic [IW-1:0]      last, grant, pick;
  logic               pick_vld;
  logic               timeout_hit;
  logic [WIDTH-1:0]   mul_a_q, mul_b_q;
  logic [2*WIDTH-1:0] result_q;
  logic               err_q;
  logic [NREQ-1:0]    ack_d;
  int                 idx;

  // Scan downward so the candidate closest after 'last' is the one left standing.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (bus.req[idx]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == WAIT && !bus.mul_done && !timeout_hit) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end
`else
  // Without the watchdog TIMEOUT has no effect; this folds to constant 0.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (bus.mul_done || timeout_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= IW'(NREQ - 1);
      grant    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          grant   <= pick;
          mul_a_q <= bus.op_a[int'(pick)*WIDTH +: WIDTH];
          mul_b_q <= bus.op_b[int'(pick)*WIDTH +: WIDTH];
        end
        // MulDone takes precedence over a coincident terminal count.
        WAIT: if (bus.mul_done) begin
          result_q <= bus.mul_p;
          err_q    <= 1'b0;
        end else if (timeout_hit) begin
          result_q <= '0;
          err_q    <= 1'b1;
        end
        RESP: last <= grant;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_d = '0;
    if (state == RESP) ack_d[grant] = 1'b1;
  end

  assign bus.ack    = ack_d;
  assign bus.result = (state == RESP) ? result_q : '0;
  assign bus.err    = (state == RESP) & err_q;
  assign bus.busy   = (state != IDLE);
  assign bus.mul_st = (state == START);
  assign bus.mul_a  = mul_a_q;
  assign bus.mul_b  = mul_b_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized self-checking bench for mul_arbiter against a round-robin reference model and a behavioural multiplier.
module tb_mul_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

  mul_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural multiplier: done pulses mul_lat cycles after start is seen (0 = never).
  int          mul_lat = 5;
  int          mcnt;
  int          n_st = 0;
  logic [15:0] mp;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt         = 0;
      bus.mul_done = 1'b0;
      bus.mul_p    = '0;
    end else begin
      bus.mul_done = 1'b0;
      bus.mul_p    = 16'($urandom);
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          bus.mul_done = 1'b1;
          bus.mul_p    = mp;
        end
      end
      if (bus.mul_st) begin
        n_st++;
        mp   = 16'(bus.mul_a) * 16'(bus.mul_b);
        mcnt = mul_lat;
      end
    end
  end

  logic [NREQ-1:0] pending;
  logic [W-1:0]    opa [NREQ];
  logic [W-1:0]    opb [NREQ];
  int              last_m;

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int lst);
    for (int k = 1; k <= NREQ; k++)
      if (m[(lst + k) % NREQ]) return (lst + k) % NREQ;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.op_a[i*W +: W] = opa[i];
      bus.op_b[i*W +: W] = opb[i];
    end
    bus.req = pending;
  endtask

  task automatic wait_ack(output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != '0) seen = 1'b1;
    end
    chk("ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic count_acks(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.ack != '0) c++;
    end
  endtask

  // Checks one completion against the model, then retires the winner from 'pending'.
  task automatic expect_ack(input string tag);
    int w, cyc;
    w = rr_pick(pending, last_m);
    wait_ack(cyc);
    chk({tag, "_ack"}, 32'(bus.ack), 32'(1) << w);
    chk({tag, "_res"}, 32'(bus.result), 32'(opa[w]) * 32'(opb[w]));
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    last_m = w;
  endtask

  initial begin
    int c, cyc, st0;
    bus.req  = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    pending  = '0;
    last_m   = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end

    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_mul", {15'd0, bus.mul_st, bus.mul_a, bus.mul_b}, 0);
    chk("rst_err", 32'(bus.err), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rel_busy", 32'(bus.busy), 0);

    // All four requesting with held levels: order 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = W'(17 + 60 * i);
      opb[i] = W'(3 + 50 * i);
    end
    opa[3] = 8'd255; opb[3] = 8'd255;
    pending = 4'b1111;
    mul_lat = 3;
    drive();
    for (int n = 0; n < 5; n++) expect_ack("rr");
    pending = '0; drive();

    // Single request 13 x 11 with a 10-cycle multiplier.
    @(negedge clk);
    opa[0] = 8'd13; opb[0] = 8'd11; pending = 4'b0001; mul_lat = 10;
    st0 = n_st;
    drive();
    @(negedge clk);
    chk("busy_rise", 32'(bus.busy), 1);
    chk("st_high", 32'(bus.mul_st), 1);
    expect_ack("single");
    chk("single_mul_a", 32'(bus.mul_a), 13);
    chk("single_mul_b", 32'(bus.mul_b), 11);
    chk("single_st_cnt", 32'(n_st - st0), 1);
    pending = '0; drive();

    // Skip/wrap: serve 2 alone, then 0011 goes 0 then 1.
    opa[2] = 8'd9; opb[2] = 8'd7; pending = 4'b0100; mul_lat = 2; drive();
    expect_ack("wrap2");
    pending = 4'b0011; opa[0] = 8'd5; opb[0] = 8'd6; opa[1] = 8'd200; opb[1] = 8'd2;
    drive();
    expect_ack("wrap0");
    pending[0] = 1'b0; drive();
    expect_ack("wrap1");
    pending = '0; drive();

    // Requester 1 withdraws while 0 is being served: only 0 completes.
    @(negedge clk);
    pending = 4'b0001; opa[0] = 8'd4; opb[0] = 8'd4; mul_lat = 8; drive();
    repeat (3) @(negedge clk);
    bus.req[1] = 1'b1;
    repeat (2) @(negedge clk);
    bus.req[1] = 1'b0;
    expect_ack("drop0");
    pending = '0; drive();
    count_acks(20, c);
    chk("drop_no_ack", 32'(c), 0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      if (pending == '0) begin
        int r;
        r = $urandom_range(0, NREQ - 1);
        pending[r] = 1'b1;
        opa[r] = W'($urandom); opb[r] = W'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      mul_lat = $urandom_range(1, 6);
      drive();
      expect_ack("rand");
      pending[last_m] = 1'($urandom_range(0, 1));
      opa[last_m] = W'($urandom); opb[last_m] = W'($urandom);
      for (int i = 0; i < NREQ; i++)
        if (!pending[i] && i != last_m && $urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          opa[i] = W'($urandom); opb[i] = W'($urandom);
        end
      drive();
    end
    pending = '0; drive();
    repeat (8) @(negedge clk);

    // Reset while waiting on the multiplier discards the operation.
    opa[2] = 8'd77; opb[2] = 8'd3; pending = 4'b0100; mul_lat = 0; drive();
    repeat (6) @(negedge clk);
    chk("mw_busy", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mw_rst_busy", 32'(bus.busy), 0);
    chk("mw_rst_mul", {15'd0, bus.mul_st, bus.mul_a, bus.mul_b}, 0);
    chk("mw_rst_ack", 32'(bus.ack), 0);
    pending = '0; drive();
    last_m = NREQ - 1;
    @(negedge clk); rst_n = 1'b1;
    count_acks(10, c);
    chk("mw_no_ack", 32'(c), 0);
    opa[1] = 8'd200; opb[1] = 8'd3; pending = 4'b0010; mul_lat = 3; drive();
    expect_ack("post_rst");
    pending = '0; drive();

`ifdef MUL_ARB_TIMEOUT_EN
    // Never-done multiplier, then done on the 64th WAIT cycle.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      opa[0] = 8'd7; opb[0] = 8'd9; pending = 4'b0001;
      mul_lat = (t == 0) ? 0 : 64;
      drive();
      cyc = 0;
      while (!bus.mul_st && cyc < 10) begin @(negedge clk); cyc++; end
      chk("to_st", 32'(bus.mul_st), 1);
      wait_ack(cyc);
      chk("to_cycles", 32'(cyc), 65);
      chk("to_ack", 32'(bus.ack), 1);
      chk("to_err", 32'(bus.err), (t == 0) ? 1 : 0);
      chk("to_res", 32'(bus.result), (t == 0) ? 0 : 63);
      last_m = 0;
      pending = '0; drive();
    end
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
